// File: rtl/ysyx_24070014_lsu_pkg.sv
// Shared definitions for the ysyx_24070014 load/store unit:
//   size codes, response error codes, LSU FSM states and the
//   byte-strobe width helper used to size strobe/offset fields.
package ysyx_24070014_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_BUSERR   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  // Number of byte lanes on a DATA_LEN-wide bus.
  function automatic int unsigned strb_len(input int unsigned data_len);
    return data_len / 8;
  endfunction

endpackage

// File: rtl/ysyx_24070014_lsu_align.sv
// Combinational lane logic for the LSU.
//   Store side: byte strobes and lane-replicated write data from size/offset.
//   Load side : lane extraction of bus read data plus sign/zero extension.
// Ports:
//   size, offset, is_unsigned : access attributes (offset = addr mod lanes)
//   wdata                      : right-aligned store data
//   rdata                      : raw bus read data
//   wstrb, wdata_rep           : store strobes / replicated store data
//   rdata_ext                  : extracted and extended load data
module ysyx_24070014_lsu_align
  import ysyx_24070014_lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  size_e                                   size,
  input  logic [$clog2(strb_len(DATA_LEN))-1:0]  offset,
  input  logic                                    is_unsigned,
  input  logic [DATA_LEN-1:0]                     wdata,
  input  logic [DATA_LEN-1:0]                     rdata,
  output logic [strb_len(DATA_LEN)-1:0]           wstrb,
  output logic [DATA_LEN-1:0]                     wdata_rep,
  output logic [DATA_LEN-1:0]                     rdata_ext
);

  localparam int unsigned STRB = strb_len(DATA_LEN);

  logic [DATA_LEN-1:0] shifted;

  always_comb begin
    wstrb     = '0;
    wdata_rep = '0;
    unique case (size)
      SIZE_B: begin
        wstrb     = STRB'(1'b1) << offset;
        wdata_rep = {(DATA_LEN/8){wdata[7:0]}};
      end
      SIZE_H: begin
        wstrb     = STRB'(2'b11) << offset;
        wdata_rep = {(DATA_LEN/16){wdata[15:0]}};
      end
      SIZE_W: begin
        wstrb     = STRB'(4'hF) << offset;
        wdata_rep = {(DATA_LEN/32){wdata[31:0]}};
      end
      SIZE_D: begin
        wstrb     = '1;
        wdata_rep = wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from the access width.
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    rdata_ext = '0;
    unique case (size)
      SIZE_B: rdata_ext = is_unsigned ? DATA_LEN'(shifted[7:0])
                                      : DATA_LEN'($signed(shifted[7:0]));
      SIZE_H: rdata_ext = is_unsigned ? DATA_LEN'(shifted[15:0])
                                      : DATA_LEN'($signed(shifted[15:0]));
      SIZE_W: rdata_ext = is_unsigned ? DATA_LEN'(shifted[31:0])
                                      : DATA_LEN'($signed(shifted[31:0]));
      SIZE_D: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_24070014_lsu.sv
// Load/store unit: accepts one access from execute, checks alignment,
// issues a single handshaked bus transaction and returns extended load
// data (or an error code) to writeback. One transaction in flight.
// Ports:
//   clk, reset (sync, active-low)
//   req_*  : request from execute (valid/ready handshake)
//   resp_* : response to writeback (valid/ready handshake)
//   mem_*  : bus request (req/gnt) and response (rvalid/rdata/err)
//   busy   : FSM not idle
// Optional feature: define YSYX_24070014_LSU_TIMEOUT_EN to enable a bus
// watchdog that answers with a timeout error after TIMEOUT_CYCLES.
module ysyx_24070014_lsu
  import ysyx_24070014_lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN       = 32,
  parameter int unsigned ADDR_LEN       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [ADDR_LEN-1:0]       req_addr,
  input  logic [DATA_LEN-1:0]       req_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_LEN-1:0]       resp_rdata,
  output logic [REG_ADDR_WIDTH-1:0] resp_rd,
  output logic [1:0]                resp_err,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic                      mem_we,
  output logic [ADDR_LEN-1:0]       mem_addr,
  output logic [DATA_LEN-1:0]       mem_wdata,
  output logic [DATA_LEN/8-1:0]     mem_wstrb,
  input  logic                      mem_rvalid,
  input  logic [DATA_LEN-1:0]       mem_rdata,
  input  logic                      mem_err,
  output logic                      busy
);

  localparam int unsigned STRB  = strb_len(DATA_LEN);
  localparam int unsigned OFF_W = $clog2(STRB);

  state_e                    state_q, state_d;
  logic [ADDR_LEN-1:0]       addr_q;
  size_e                     size_q;
  logic                      we_q, uns_q;
  logic [DATA_LEN-1:0]       wdata_q, rdata_q, rdata_d, ld_data, wdata_rep;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  err_e                      err_q, err_d;
  logic [STRB-1:0]           strb;
  logic                      accept, misalign, resp_load;

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    misalign = 1'b0;
    unique case (req_size)
      2'b00: misalign = 1'b0;
      2'b01: misalign = req_addr[0];
      2'b10: misalign = |req_addr[1:0];
      2'b11: misalign = (DATA_LEN == 32) || (|req_addr[2:0]);
    endcase
  end

`ifdef YSYX_24070014_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  // Held at zero while idle, so it starts from zero on every entry to REQ.
  always_ff @(posedge clk) begin
    if (!reset || state_q == IDLE || state_q == RESP) tmo_cnt_q <= '0;
    else                                              tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == REQ || state_q == WAIT) &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    resp_load = 1'b0;
    err_d     = ERR_OK;
    rdata_d   = '0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        if (misalign) begin
          state_d   = RESP;
          resp_load = 1'b1;
          err_d     = ERR_MISALIGN;
        end else begin
          state_d = REQ;
        end
      end
      REQ:  if (mem_gnt) state_d = WAIT;
      WAIT: if (mem_rvalid) begin
        state_d   = RESP;
        resp_load = 1'b1;
        if (mem_err)    err_d   = ERR_BUSERR;
        else if (!we_q) rdata_d = ld_data;
      end
      RESP: if (resp_ready) state_d = IDLE;
    endcase
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
    // A response arriving on the expiry cycle still wins over the watchdog.
    if (tmo_hit && !resp_load) begin
      state_d   = RESP;
      resp_load = 1'b1;
      err_d     = ERR_TIMEOUT;
      rdata_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      size_q  <= SIZE_B;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= size_e'(req_size);
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
      end
      if (resp_load) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  ysyx_24070014_lsu_align #(
    .DATA_LEN(DATA_LEN)
  ) u_align (
    .size       (size_q),
    .offset     (addr_q[OFF_W-1:0]),
    .is_unsigned(uns_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wstrb      (strb),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (ld_data)
  );

  // Bus and response fields are driven only in their owning state, so every
  // output other than req_ready reads zero while idle and after reset.
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_req    = (state_q == REQ);
  assign mem_we     = mem_req && we_q;
  assign mem_addr   = mem_req ? {addr_q[ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wstrb  = mem_req ? strb : '0;
  assign mem_wdata  = mem_req ? wdata_rep : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_rd    = resp_valid ? rd_q : '0;
  assign resp_err   = resp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
module tb_ysyx_24070014_lsu;

  localparam int DL = 32;
  localparam int AL = 32;
  localparam int RW = 5;
  localparam int NB = DL / 8;
`ifdef YSYX_24070014_LSU_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AL-1:0] req_addr;
  logic [DL-1:0] req_wdata;
  logic [RW-1:0] req_rd;
  logic          resp_valid, resp_ready;
  logic [DL-1:0] resp_rdata;
  logic [RW-1:0] resp_rd;
  logic [1:0]    resp_err;
  logic          mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [AL-1:0] mem_addr;
  logic [DL-1:0] mem_wdata, mem_rdata;
  logic [NB-1:0] mem_wstrb;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24070014_lsu #(
    .DATA_LEN(DL), .ADDR_LEN(AL), .REG_ADDR_WIDTH(RW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: take (1<<sz) bytes starting at byte off, then extend.
  function automatic logic [DL-1:0] ref_load(logic [DL-1:0] raw, int off, int sz, bit uns);
    logic [63:0] v = '0;
    int nb = 1 << sz;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
    if (!uns && v[8*nb-1]) for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
    return v[DL-1:0];
  endfunction

  function automatic logic [NB-1:0] ref_strb(int off, int sz);
    logic [NB-1:0] s = '0;
    for (int i = 0; i < (1 << sz); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [DL-1:0] ref_wdata(logic [DL-1:0] wd, int sz);
    logic [DL-1:0] w = '0;
    for (int i = 0; i < NB; i++) w[8*i +: 8] = wd[8*(i % (1 << sz)) +: 8];
    return w;
  endfunction

  task automatic run(input bit we, input int sz, input bit uns, input logic [AL-1:0] addr,
                     input logic [DL-1:0] wd, input logic [RW-1:0] rd, input int gd,
                     input int rvd, input logic [DL-1:0] rdat, input bit berr, input int rrd);
    int            off = int'(addr % NB);
    bit            mis;
    logic [DL-1:0] er;
    logic [1:0]    ee;
    mis = (sz == 3 && DL == 32) || (addr % (1 << sz) != 0);
    if (mis)       begin ee = 2'b01; er = '0; end
    else if (berr) begin ee = 2'b10; er = '0; end
    else if (we)   begin ee = 2'b00; er = '0; end
    else           begin ee = 2'b00; er = ref_load(rdat, off, sz, uns); end

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_size = 2'(sz); req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_wdata = $urandom; req_addr = $urandom; req_rd = 5'($urandom);
    if (!mis) begin
      for (int i = 0; i <= gd; i++) begin
        chk("mem_req_req", mem_req, 1);
        chk("busy_req", busy, 1);
        chk("mem_addr", mem_addr, addr & ~AL'(NB - 1));
        chk("mem_we", mem_we, we);
        chk("mem_wstrb", mem_wstrb, ref_strb(off, sz));
        if (we) chk("mem_wdata", mem_wdata, ref_wdata(wd, sz));
        if (i == gd) mem_gnt = 1;
        else         mem_rvalid = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0;
      end
      for (int i = 0; i <= rvd; i++) begin
        chk("mem_req_wait", mem_req, 0);
        chk("resp_valid_wait", resp_valid, 0);
        if (i == rvd) begin mem_rvalid = 1; mem_rdata = rdat; mem_err = berr; end
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 0; mem_err = 0; mem_rdata = $urandom;
      end
    end else begin
      chk("mem_req_misalign", mem_req, 0);
    end
    for (int i = 0; i <= rrd; i++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_rdata", resp_rdata, er);
      chk("resp_rd", resp_rd, rd);
      chk("resp_err", resp_err, ee);
      chk("req_ready_resp", req_ready, 0);
      chk("mem_req_resp", mem_req, 0);
      if (i == rrd) resp_ready = 1;
      else begin mem_rvalid = 1'($urandom); mem_gnt = 1'($urandom); end
      @(posedge clk);
      @(negedge clk);
      resp_ready = 0; mem_rvalid = 0; mem_gnt = 0;
    end
    chk("resp_valid_done", resp_valid, 0);
    chk("req_ready_done", req_ready, 1);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    reset = 1;

    // LB signed, minimum latency
    run(0, 0, 0, 32'h8000_0003, '0, 5'd1, 0, 0, 32'h80AA_BBCC, 0, 0);
    // SH store
    run(1, 1, 0, 32'h8000_0002, 32'h0000_BEEF, 5'd2, 0, 0, 32'h1111_1111, 0, 0);
    // LW misaligned
    run(0, 2, 0, 32'h8000_0006, '0, 5'd3, 0, 0, '0, 0, 0);
    // LHU with 5-cycle grant stall and bus error
    run(0, 1, 1, 32'h8000_0000, '0, 5'd4, 5, 0, 32'h1234_F00D, 1, 0);
    // LHU ok
    run(0, 1, 1, 32'h8000_0000, '0, 5'd5, 0, 1, 32'h1234_F00D, 0, 0);
    // LW with writeback stalled 4 cycles
    run(0, 2, 0, 32'h8000_0010, '0, 5'd6, 1, 2, 32'hDEAD_BEEF, 0, 4);
    // Doubleword on a 32-bit bus is rejected
    run(0, 3, 0, 32'h8000_0000, '0, 5'd7, 0, 0, '0, 0, 0);

    // Stray bus handshakes while idle
    @(negedge clk);
    mem_gnt = 1; mem_rvalid = 1;
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 0;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_mem_req", mem_req, 0);

    // Reset while waiting for the bus response
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h8000_0020; req_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 0;
    chk("wait_busy", busy, 1);
    chk("wait_mem_req", mem_req, 0);
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    chk("rstwait_busy", busy, 0);
    chk("rstwait_mem_req", mem_req, 0);
    chk("rstwait_req_ready", req_ready, 1);
    chk("rstwait_resp_valid", resp_valid, 0);
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 0;
    chk("late_rvalid_resp_valid", resp_valid, 0);
    chk("late_rvalid_busy", busy, 0);

`ifdef YSYX_24070014_LSU_TIMEOUT_EN
    begin
      int n = 0;
      req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h8000_0040; req_rd = 5'd11;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0; mem_gnt = 1;
      while (!resp_valid && n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        mem_gnt = 0;
      end
      chk("timeout_cycles", 64'(n), 64'(TMO));
      chk("timeout_err", resp_err, 2'b11);
      chk("timeout_rdata", resp_rdata, 0);
      chk("timeout_mem_req", mem_req, 0);
      mem_rvalid = 1; mem_rdata = 32'h5555_5555;
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 0;
      chk("timeout_hold_err", resp_err, 2'b11);
      resp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 0;
      chk("timeout_done_busy", busy, 0);
    end
`endif

    // Randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      int               sz = int'($urandom_range(0, 3));
      logic [AL-1:0]    a  = 32'h8000_0000 | AL'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~AL'((1 << sz) - 1);
      run(1'($urandom), sz, 1'($urandom), a, $urandom, 5'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24070014_lsu.md
Name: ysyx_24070014_lsu

Overview:
Parametrised load/store unit. It replaces the core's direct, zero-latency, mask-less DPI memory access with a handshaked, multi-cycle memory port. It accepts one load/store from the execute stage, checks alignment, generates byte strobes, issues one bus transaction and waits for the response. For loads it returns lane-extracted, sign- or zero-extended data to writeback. It sits between the ALU address output and the register-file writeback mux.

Parameters:
DATA_LEN, 32, bus and register data width; 32 or 64 only.
ADDR_LEN, 32, address width.
REG_ADDR_WIDTH, 5, width of the destination-register tag.
TIMEOUT_CYCLES, 256, bus watchdog limit; used only with the optional feature.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  execute stage presents an access
req_ready  out  1  LSU can accept an access
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 = B, 01 = H, 10 = W, 11 = D (DATA_LEN = 64 only)
req_unsigned  in  1  zero-extend the load result
req_addr  in  ADDR_LEN  byte address
req_wdata  in  DATA_LEN  store data, right-aligned
req_rd  in  REG_ADDR_WIDTH  destination tag, echoed on the response
resp_valid  out  1  result available
resp_ready  in  1  writeback consumes the result
resp_rdata  out  DATA_LEN  extended load data; 0 for stores and errors
resp_rd  out  REG_ADDR_WIDTH  echoed tag
resp_err  out  2  00 = ok, 01 = misaligned, 10 = bus error, 11 = timeout
mem_req  out  1  bus request
mem_gnt  in  1  bus accepted the request
mem_we  out  1  bus write
mem_addr  out  ADDR_LEN  address aligned down to a DATA_LEN/8 boundary
mem_wdata  out  DATA_LEN  lane-replicated store data
mem_wstrb  out  DATA_LEN/8  byte strobes
mem_rvalid  in  1  bus response
mem_rdata  in  DATA_LEN  bus read data
mem_err  in  1  bus error, qualified by mem_rvalid
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Exactly one transaction is outstanding at a time.
- Reset (reset = 0 at a clk edge):
  - state <= IDLE.
  - All outputs are 0 except req_ready = 1.
  - Any in-flight transaction is dropped; mem_req is low from the next cycle.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, size, we, unsigned, wdata and rd.
  - If misaligned (addr mod 2^size != 0), or size = 11 with DATA_LEN = 32: go to RESP with err = 01. No bus traffic.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1; mem_we, mem_addr, mem_wdata and mem_wstrb stay stable until mem_gnt.
  - When mem_gnt = 1, go to WAIT; mem_req drops in the following cycle.
- WAIT:
  - On mem_rvalid, go to RESP.
  - If mem_err = 1: err = 10, rdata = 0.
  - Else if load: rdata = extract of mem_rdata at byte offset addr mod (DATA_LEN/8), sign- or zero-extended per req_unsigned.
  - Else (store): rdata = 0.
  - mem_rvalid is honoured only in WAIT. The earliest legal rvalid is the cycle after gnt.
- RESP:
  - resp_valid = 1; all resp_* fields are held stable until resp_ready.
  - On resp_ready, go to IDLE. A new request can be accepted the cycle after.
- Minimum latency: accept at T, gnt at T+1, rvalid at T+2, resp_valid at T+3.
- Strobes: B = 1<<off, H = 3<<off, W = 0xF<<off, D = 0xFF.
- Store data: the byte is replicated to every lane, the halfword to every halfword lane, the word to both word lanes.
- Stray mem_rvalid or mem_gnt in IDLE, RESP or REQ-without-request is ignored.

Optional Feature:
Macro YSYX_24070014_LSU_TIMEOUT_EN.
- With it: a counter clears on entry to REQ and increments every cycle spent in REQ or WAIT. When it reaches TIMEOUT_CYCLES, go to RESP with err = 11 and rdata = 0. mem_req is withdrawn. Any later rvalid is ignored.
- Without it: there is no counter; the LSU waits indefinitely and err = 11 is never produced.

Decomposition:
- Package ysyx_24070014_lsu_pkg holds:
  - size codes (B/H/W/D);
  - error codes (OK, MISALIGN, BUSERR, TIMEOUT);
  - the FSM state enum;
  - a STRB_LEN = DATA_LEN/8 helper function.
- Sub-module ysyx_24070014_lsu_align, purely combinational:
  - store side: strobe and replicated write data from size and offset;
  - load side: lane extract plus sign/zero extension from size, offset and unsigned.

Test Plan:
- LB, addr 0x80000003, mem_rdata 0x80AABBCC, unsigned = 0, gnt and rvalid at the earliest cycles -> resp_rdata 0xFFFFFF80, err 00, mem_addr 0x80000000, resp_valid at T+3.
- SH, addr 0x80000002, wdata 0x0000BEEF -> mem_wstrb 4'b1100, mem_wdata 0xBEEFBEEF, mem_we 1, resp_rdata 0.
- LW, addr 0x80000006 -> err 01, resp_valid at T+1, mem_req never asserted.
- LHU, addr 0x80000000, gnt held low for 5 cycles, then mem_rvalid with mem_err = 1 -> mem_req held with stable fields for 5 cycles, then err 10, rdata 0. A second LHU of mem_rdata 0x1234F00D -> rdata 0x0000F00D.
- resp_ready held low for 4 cycles -> resp_* stable, req_ready stays 0. reset = 0 asserted in WAIT -> IDLE next cycle, mem_req 0, a later rvalid is ignored.
- With TIMEOUT_EN and TIMEOUT_CYCLES = 8, gnt given but rvalid never -> err 11 exactly 8 cycles after entering REQ.
